// File: rtl/router_switch.sv
// rtl/router_switch.sv - two-state ingress-to-egress byte router with drop/error accounting
module router_switch #(
  parameter int CNT_W  = 16,
  parameter int DROP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        source,
  input  logic [1:0]        destination,
  input  logic              valid,
  input  logic [3:0]        fifo_empty,
  input  logic [3:0]        fifo_full,
  input  logic [7:0]        router_data_out_0,
  input  logic [7:0]        router_data_out_1,
  input  logic [7:0]        router_data_out_2,
  input  logic [7:0]        router_data_out_3,
  input  logic              err_clr,
  output logic [3:0]        fifo_rd_en,
  output logic [3:0]        out_wr_en,
  output logic [7:0]        out_data,
  output logic              busy,
  output logic [CNT_W-1:0]  xfer_count,
  output logic [DROP_W-1:0] drop_count,
  output logic [3:0]        err_status
);

  typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_e;

  state_e              state_q, state_d;
  logic [1:0]          src_q, src_d;
  logic [1:0]          dst_q, dst_d;
  logic [7:0]          hdr_q, hdr_d;
  logic [3:0]          rd_q, rd_d;
  logic [3:0]          wr_q, wr_d;
  logic [7:0]          data_q, data_d;
  logic                busy_q, busy_d;
  logic [CNT_W-1:0]    xfer_q, xfer_d;
  logic [DROP_W-1:0]   drop_q, drop_d;
  logic [3:0]          err_q, err_d;
  logic [3:0]          err_set;
  logic [1:0]          drop_inc;
  logic [DROP_W:0]     drop_sum;
  logic [7:0]          head_byte;

  // Peek the head byte of the ingress FIFO selected by the arbiter
  always_comb begin
    head_byte = router_data_out_0;
    case (source)
      2'd0: head_byte = router_data_out_0;
      2'd1: head_byte = router_data_out_1;
      2'd2: head_byte = router_data_out_2;
      2'd3: head_byte = router_data_out_3;
      default: head_byte = router_data_out_0;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: a request is accepted in IDLE and always resolved in one XFER cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (valid) state_d = XFER;
      XFER:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output/datapath next values: latch in IDLE, evaluate in XFER with fixed check priority
  always_comb begin
    src_d    = src_q;
    dst_d    = dst_q;
    hdr_d    = hdr_q;
    rd_d     = 4'b0000;
    wr_d     = 4'b0000;
    data_d   = 8'h00;
    xfer_d   = xfer_q;
    err_set  = 4'b0000;
    drop_inc = 2'd0;
    case (state_q)
      IDLE: begin
        if (valid) begin
          src_d = source;
          dst_d = destination;
          hdr_d = head_byte;
        end
      end
      XFER: begin
        if (fifo_empty[src_q]) begin
          err_set[0] = 1'b1;
          drop_inc   = 2'd1;
        end else if (fifo_full[dst_q]) begin
          // Byte stays in the ingress FIFO so the arbiter can retry it
          err_set[1] = 1'b1;
          drop_inc   = 2'd1;
        end else if (hdr_q[5:4] != dst_q) begin
          // Misrouted byte is flushed from the ingress FIFO
          rd_d       = 4'b0001 << src_q;
          err_set[2] = 1'b1;
          drop_inc   = 2'd1;
        end else begin
          rd_d   = 4'b0001 << src_q;
          wr_d   = 4'b0001 << dst_q;
          data_d = hdr_q;
          xfer_d = xfer_q + CNT_W'(1);
        end
        // A new request arriving mid-transfer is counted and discarded
        if (valid) begin
          err_set[3] = 1'b1;
          drop_inc   = drop_inc + 2'd1;
        end
      end
      default: ;
    endcase
    busy_d   = (state_d == XFER);
    err_d    = (err_clr ? 4'b0000 : err_q) | err_set;
    drop_sum = {1'b0, drop_q} + {{(DROP_W-1){1'b0}}, drop_inc};
    drop_d   = drop_sum[DROP_W] ? {DROP_W{1'b1}} : drop_sum[DROP_W-1:0];
  end

  // Registered datapath and outputs; reset aborts any in-flight request
  always_ff @(posedge clk) begin
    if (rst) begin
      src_q  <= 2'd0;
      dst_q  <= 2'd0;
      hdr_q  <= 8'h00;
      rd_q   <= 4'b0000;
      wr_q   <= 4'b0000;
      data_q <= 8'h00;
      busy_q <= 1'b0;
      xfer_q <= '0;
      drop_q <= '0;
      err_q  <= 4'b0000;
    end else begin
      src_q  <= src_d;
      dst_q  <= dst_d;
      hdr_q  <= hdr_d;
      rd_q   <= rd_d;
      wr_q   <= wr_d;
      data_q <= data_d;
      busy_q <= busy_d;
      xfer_q <= xfer_d;
      drop_q <= drop_d;
      err_q  <= err_d;
    end
  end

  assign fifo_rd_en = rd_q;
  assign out_wr_en  = wr_q;
  assign out_data   = data_q;
  assign busy       = busy_q;
  assign xfer_count = xfer_q;
  assign drop_count = drop_q;
  assign err_status = err_q;

endmodule

// File: tb/tb_router_switch.sv
// tb/tb_router_switch.sv - scoreboard bench for router_switch with randomized traffic
module tb_router_switch;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  source, destination;
  logic        valid;
  logic [3:0]  fifo_empty, fifo_full;
  logic [7:0]  rdo [4];
  logic        err_clr;
  logic [3:0]  fifo_rd_en, out_wr_en;
  logic [7:0]  out_data;
  logic        busy;
  logic [15:0] xfer_count;
  logic [7:0]  drop_count;
  logic [3:0]  err_status;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic [3:0] rd;
    logic [3:0] wr;
    logic [7:0] data;
    int         cyc;
  } exp_t;
  exp_t exp_q[$];

  // Reference state: request bookkeeping at transaction level
  bit         m_pending;
  int         m_src, m_dst;
  logic [7:0] m_hdr;
  int         m_xfer, m_drop;
  logic [3:0] m_err;

  router_switch #(.CNT_W(16), .DROP_W(8)) dut (
    .clk(clk), .rst(rst), .source(source), .destination(destination), .valid(valid),
    .fifo_empty(fifo_empty), .fifo_full(fifo_full),
    .router_data_out_0(rdo[0]), .router_data_out_1(rdo[1]),
    .router_data_out_2(rdo[2]), .router_data_out_3(rdo[3]),
    .err_clr(err_clr), .fifo_rd_en(fifo_rd_en), .out_wr_en(out_wr_en), .out_data(out_data),
    .busy(busy), .xfer_count(xfer_count), .drop_count(drop_count), .err_status(err_status)
  );

  always #5 clk = ~clk;

  // Reference model: resolves each request one cycle after acceptance
  always @(posedge clk) begin
    logic [3:0] set;
    int inc;
    exp_t e;
    cyc = cyc + 1;
    if (rst) begin
      m_pending = 0; m_src = 0; m_dst = 0; m_hdr = 0;
      m_xfer = 0; m_drop = 0; m_err = 0;
    end else begin
      set = 0; inc = 0;
      if (m_pending) begin
        if (fifo_empty[m_src]) begin
          set[0] = 1; inc++;
        end else if (fifo_full[m_dst]) begin
          set[1] = 1; inc++;
        end else if (int'(m_hdr[5:4]) != m_dst) begin
          set[2] = 1; inc++;
          e.rd = 4'(1 << m_src); e.wr = 0; e.data = 0; e.cyc = cyc;
          exp_q.push_back(e);
        end else begin
          m_xfer = (m_xfer + 1) % 65536;
          e.rd = 4'(1 << m_src); e.wr = 4'(1 << m_dst); e.data = m_hdr; e.cyc = cyc;
          exp_q.push_back(e);
        end
        if (valid) begin
          set[3] = 1; inc++;
        end
        m_pending = 0;
      end else if (valid) begin
        m_src = int'(source); m_dst = int'(destination); m_hdr = rdo[source];
        m_pending = 1;
      end
      m_err  = (err_clr ? 4'b0 : m_err) | set;
      m_drop = (m_drop + inc > 255) ? 255 : m_drop + inc;
    end
  end

  // Monitor: pops the scoreboard whenever strobes appear, and tracks status each cycle
  always @(negedge clk) begin
    exp_t e;
    if (cyc >= 1) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        checks++; failures++;
        $display("FAIL missing_strobe cyc=%0d actual rd=%b wr=%b required rd=%b wr=%b",
                 cyc, fifo_rd_en, out_wr_en, exp_q[0].rd, exp_q[0].wr);
        void'(exp_q.pop_front());
      end
      if ((fifo_rd_en | out_wr_en) !== 4'b0) begin
        checks++;
        if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
          failures++;
          $display("FAIL unexpected_strobe cyc=%0d actual rd=%b wr=%b required none",
                   cyc, fifo_rd_en, out_wr_en);
        end else begin
          e = exp_q.pop_front();
          if (fifo_rd_en !== e.rd || out_wr_en !== e.wr || (e.wr != 0 && out_data !== e.data)) begin
            failures++;
            $display("FAIL strobe cyc=%0d actual rd=%b wr=%b data=%h required rd=%b wr=%b data=%h",
                     cyc, fifo_rd_en, out_wr_en, out_data, e.rd, e.wr, e.data);
          end
        end
      end
      checks++;
      if (busy !== m_pending || xfer_count !== 16'(m_xfer) || drop_count !== 8'(m_drop) ||
          err_status !== m_err) begin
        failures++;
        $display("FAIL status cyc=%0d actual busy=%b xfer=%0d drop=%0d err=%b required busy=%b xfer=%0d drop=%0d err=%b",
                 cyc, busy, xfer_count, drop_count, err_status, m_pending, m_xfer, m_drop, m_err);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Issue one request: valid for one edge, returns right after the evaluation edge
  task automatic req(input logic [1:0] s, input logic [1:0] d);
    source = s; destination = d; valid = 1'b1;
    tick();
    valid = 1'b0;
    tick();
  endtask

  initial begin
    logic [7:0] d0;
    rst = 1'b1; valid = 0; source = 0; destination = 0; err_clr = 0;
    fifo_empty = 0; fifo_full = 0;
    for (int i = 0; i < 4; i++) rdo[i] = 8'h00;
    tick(); tick();
    chk("reset_xfer", 32'(xfer_count), 0);
    chk("reset_drop", 32'(drop_count), 0);
    chk("reset_err", 32'(err_status), 0);
    chk("reset_busy", 32'(busy), 0);
    rst = 1'b0;
    tick();

    // Successful transfer
    rdo[2] = 8'h15;
    source = 2; destination = 1; valid = 1;
    tick();
    chk("busy_in_xfer", 32'(busy), 1);
    valid = 0;
    tick();
    chk("ok_rd", 32'(fifo_rd_en), 32'b0100);
    chk("ok_wr", 32'(out_wr_en), 32'b0010);
    chk("ok_data", 32'(out_data), 32'h15);
    chk("ok_xfer", 32'(xfer_count), 1);
    tick();
    chk("ok_strobe_one_cycle", 32'(fifo_rd_en | out_wr_en), 0);

    // Destination full
    fifo_full = 4'b1000; rdo[0] = 8'h30;
    req(0, 3);
    chk("full_rd", 32'(fifo_rd_en | out_wr_en), 0);
    chk("full_err", 32'(err_status), 32'b0010);
    chk("full_drop", 32'(drop_count), 1);
    fifo_full = 0;

    // Header mismatch flushes only
    rdo[1] = 8'h30;
    req(1, 2);
    chk("mis_rd", 32'(fifo_rd_en), 32'b0010);
    chk("mis_wr", 32'(out_wr_en), 0);
    chk("mis_err2", 32'(err_status[2]), 1);
    err_clr = 1; tick(); err_clr = 0;
    chk("clr_err", 32'(err_status), 0);

    // Overrun: valid on two consecutive edges
    d0 = drop_count;
    rdo[3] = 8'h20;
    source = 3; destination = 2; valid = 1;
    tick(); tick();
    valid = 0;
    chk("ovr_err", 32'(err_status), 32'b1000);
    chk("ovr_drop", 32'(drop_count), 32'(d0 + 8'd1));
    chk("ovr_xfer", 32'(xfer_count), 2);
    tick();
    err_clr = 1; tick(); err_clr = 0;
    chk("ovr_clr", 32'(err_status), 0);

    // Drop saturation
    rst = 1; tick(); rst = 0;
    fifo_empty = 4'hF;
    for (int i = 0; i < 300; i++) req(2'(i), 2'(i + 1));
    chk("sat_drop", 32'(drop_count), 255);
    chk("sat_err", 32'(err_status), 32'b0001);
    fifo_empty = 0;

    // Reset while a request is in XFER
    rdo[0] = 8'h10;
    source = 0; destination = 1; valid = 1;
    tick();
    valid = 0; rst = 1;
    tick();
    rst = 0;
    chk("rst_xfer_strobes", 32'(fifo_rd_en | out_wr_en), 0);
    chk("rst_xfer_counts", 32'({xfer_count, drop_count}), 0);
    chk("rst_xfer_misc", 32'({busy, err_status, out_data}), 0);
    tick();
    chk("rst_xfer_after", 32'(fifo_rd_en | out_wr_en), 0);

    // Randomized traffic, including occasional overruns, clears and resets
    for (int i = 0; i < 4000; i++) begin
      source      = 2'($urandom);
      destination = 2'($urandom);
      valid       = ($urandom_range(0, 2) == 0);
      fifo_empty  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0;
      fifo_full   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0;
      for (int k = 0; k < 4; k++) begin
        rdo[k] = 8'($urandom);
        if ($urandom_range(0, 1) == 1) rdo[k][5:4] = destination;
      end
      err_clr = ($urandom_range(0, 15) == 0);
      rst     = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 0; valid = 0; err_clr = 0;
    tick(); tick();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
